// File: rtl/acc_dummy_responder.sv
// Offload responder: computes dummy-op results after a fixed latency and returns in-order tagged responses.
// Optional address check enabled by defining ACC_DUMMY_ERR_CHECK_EN.
module acc_dummy_responder #(
    parameter int DataWidth = 32,
    parameter int IdWidth   = 5,
    parameter int AccAddr   = 0,
    parameter int Latency   = 2,
    parameter int Depth     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [31:0]          req_instr_i,
    input  logic [DataWidth-1:0] req_rs1_i,
    input  logic [DataWidth-1:0] req_rs2_i,
    input  logic [DataWidth-1:0] req_rs3_i,
    input  logic [IdWidth-1:0]   req_id_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic [IdWidth-1:0]   rsp_id_o,
    output logic                 rsp_error_o
);

    typedef struct packed {
        logic                 err;
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
    } rsp_t;

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [CntW-1:0] DepthC = CntW'(Depth);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

    logic [CntW-1:0]      outstanding;
    logic                 acc_wb;
    logic                 pop;
    logic                 push_vld;
    logic                 addr_err;
    logic [DataWidth-1:0] op_res;
    rsp_t                 new_rsp;
    rsp_t                 push_rsp;

    // Ready depends only on registered credit state, never on this cycle's pop.
    assign req_ready_o = outstanding < DepthC;
    assign acc_wb      = req_valid_i & req_ready_o & req_instr_i[11];

`ifdef ACC_DUMMY_ERR_CHECK_EN
    localparam logic [4:0] AccAddrC = 5'(AccAddr);
    logic unused_instr;
    assign addr_err     = req_instr_i[31:27] != AccAddrC;
    assign unused_instr = ^{req_instr_i[26:12], req_instr_i[10:2]};
`else
    localparam int unused_acc_addr = AccAddr;
    logic unused_instr;
    assign addr_err     = 1'b0;
    assign unused_instr = ^{req_instr_i[31:12], req_instr_i[10:2]};
`endif

    always_comb begin
        op_res = '0;
        case (req_instr_i[1:0])
            2'b00:   op_res = req_rs1_i + req_rs2_i;
            2'b01:   op_res = req_rs1_i ^ req_rs2_i;
            2'b10:   op_res = req_rs1_i + req_rs2_i + req_rs3_i;
            default: op_res = req_rs1_i;
        endcase
    end

    always_comb begin
        new_rsp      = '0;
        new_rsp.err  = addr_err;
        new_rsp.id   = req_id_i;
        new_rsp.data = addr_err ? '0 : op_res;
    end

    // The FIFO write is the last latency stage, so only Latency-1 register stages precede it.
    generate
        if (Latency == 1) begin : g_nopipe
            assign push_vld = acc_wb;
            assign push_rsp = new_rsp;
        end else begin : g_pipe
            localparam int STAGES = Latency - 2;
            logic [STAGES:0] vld_pipe;
            rsp_t            rsp_pipe [STAGES+1];

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe[0] <= acc_wb;
                    for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
                end
            end

            always_ff @(posedge clk_i) begin
                rsp_pipe[0] <= new_rsp;
                for (int i = 1; i <= STAGES; i++) rsp_pipe[i] <= rsp_pipe[i-1];
            end

            assign push_vld = vld_pipe[STAGES];
            assign push_rsp = rsp_pipe[STAGES];
        end
    endgenerate

    rsp_t            mem [Depth];
    rsp_t            head;
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;
    logic [CntW-1:0] cnt;

    assign rsp_valid_o = cnt != '0;
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign head        = mem[rptr];
    assign rsp_data_o  = rsp_valid_o ? head.data : '0;
    assign rsp_id_o    = rsp_valid_o ? head.id : '0;
    assign rsp_error_o = rsp_valid_o & head.err;

    // Credit limit bounds pipeline+FIFO occupancy, so a push never finds the FIFO full.
    always_ff @(posedge clk_i) begin
        if (push_vld) mem[wptr] <= push_rsp;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr        <= '0;
            rptr        <= '0;
            cnt         <= '0;
            outstanding <= '0;
        end else begin
            if (push_vld) wptr <= (wptr == PtrLast) ? '0 : wptr + PtrW'(1);
            if (pop)      rptr <= (rptr == PtrLast) ? '0 : rptr + PtrW'(1);
            case ({push_vld, pop})
                2'b10:   cnt <= cnt + CntW'(1);
                2'b01:   cnt <= cnt - CntW'(1);
                default: cnt <= cnt;
            endcase
            case ({acc_wb, pop})
                2'b10:   outstanding <= outstanding + CntW'(1);
                2'b01:   outstanding <= outstanding - CntW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_dummy_responder.sv
// Directed bench for acc_dummy_responder (Latency=2, AccAddr=3, Depth=4).
module tb_acc_dummy_responder;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_instr_i;
    logic [31:0] req_rs1_i, req_rs2_i, req_rs3_i;
    logic [4:0]  req_id_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [4:0]  rsp_id_o;
    logic        rsp_error_o;

    int n_tests = 0;
    int n_fail  = 0;

    acc_dummy_responder #(
        .DataWidth(32), .IdWidth(5), .AccAddr(3), .Latency(2), .Depth(4)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_instr_i(req_instr_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
        .req_rs3_i(req_rs3_i), .req_id_i(req_id_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_id_o(rsp_id_o), .rsp_error_o(rsp_error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [4:0] id);
        req_valid_i = 1'b1;
        req_instr_i = instr;
        req_rs1_i   = a;
        req_rs2_i   = b;
        req_rs3_i   = c;
        req_id_i    = id;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] data, input logic [4:0] id,
                              input logic err);
        int n = 0;
        while (!rsp_valid_o && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 64'(rsp_valid_o), 64'd1);
        chk({tag, "_data"}, 64'(rsp_data_o), 64'(data));
        chk({tag, "_id"}, 64'(rsp_id_o), 64'(id));
        chk({tag, "_err"}, 64'(rsp_error_o), 64'(err));
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst_ni      = 1'b0;
        req_valid_i = 1'b0;
        req_instr_i = '0;
        req_rs1_i   = '0;
        req_rs2_i   = '0;
        req_rs3_i   = '0;
        req_id_i    = '0;
        rsp_ready_i = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        chk("rst_ready", 64'(req_ready_o), 64'd1);
        chk("rst_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_data",  64'(rsp_data_o),  64'd0);
        chk("rst_id",    64'(rsp_id_o),    64'd0);
        chk("rst_err",   64'(rsp_error_o), 64'd0);

        // Latency: accepted at t, visible at t+2
        send(32'h1800_0800, 32'd5, 32'd7, 32'd0, 5'd9);
        chk("lat_t1_valid", 64'(rsp_valid_o), 64'd0);
        tick();
        chk("lat_t2_valid", 64'(rsp_valid_o), 64'd1);
        expect_rsp("lat", 32'd12, 5'd9, 1'b0);

        // Ops sweep
        send(32'h1800_0800, 32'hFFFF_FFFF, 32'd1, 32'd2, 5'd2);
        expect_rsp("op_add", 32'h0000_0000, 5'd2, 1'b0);
        send(32'h1800_0801, 32'hFFFF_FFFF, 32'd1, 32'd2, 5'd3);
        expect_rsp("op_xor", 32'hFFFF_FFFE, 5'd3, 1'b0);
        send(32'h1800_0802, 32'hFFFF_FFFF, 32'd1, 32'd2, 5'd4);
        expect_rsp("op_add3", 32'h0000_0002, 5'd4, 1'b0);
        send(32'h1800_0803, 32'hFFFF_FFFF, 32'd1, 32'd2, 5'd5);
        expect_rsp("op_pass", 32'hFFFF_FFFF, 5'd5, 1'b0);

        // Address mismatch (accelerator 4)
        send(32'h2000_0800, 32'd5, 32'd7, 32'd0, 5'd1);
`ifdef ACC_DUMMY_ERR_CHECK_EN
        expect_rsp("addr_err", 32'd0, 5'd1, 1'b1);
`else
        expect_rsp("addr_err", 32'd12, 5'd1, 1'b0);
`endif

        // Backpressure: five back-to-back requests, four accepted
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_ready%0d", i), 64'(req_ready_o), (i < 4) ? 64'd1 : 64'd0);
            req_valid_i = 1'b1;
            req_instr_i = 32'h1800_0800;
            req_rs1_i   = 32'(i);
            req_rs2_i   = 32'd100;
            req_id_i    = 5'(10 + i);
            tick();
        end
        req_valid_i = 1'b0;
        tick();
        chk("bp_ready_hold", 64'(req_ready_o), 64'd0);
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_rsp_valid%0d", i), 64'(rsp_valid_o), 64'd1);
            chk($sformatf("bp_rsp_id%0d", i), 64'(rsp_id_o), 64'(10 + i));
            chk($sformatf("bp_rsp_data%0d", i), 64'(rsp_data_o), 64'(100 + i));
            chk($sformatf("bp_ready_pop%0d", i), 64'(req_ready_o), (i == 0) ? 64'd0 : 64'd1);
            tick();
        end
        chk("bp_drained", 64'(rsp_valid_o), 64'd0);
        rsp_ready_i = 1'b0;

        // WB=0 request in the middle is dropped silently
        send(32'h1800_0800, 32'd1, 32'd1, 32'd0, 5'd1);
        send(32'h1800_0000, 32'd2, 32'd2, 32'd0, 5'd2);
        send(32'h1800_0800, 32'd3, 32'd3, 32'd0, 5'd3);
        expect_rsp("nowb_a", 32'd2, 5'd1, 1'b0);
        expect_rsp("nowb_b", 32'd6, 5'd3, 1'b0);
        tick();
        tick();
        chk("nowb_none", 64'(rsp_valid_o), 64'd0);

        // Reset with three responses buffered
        send(32'h1800_0803, 32'd7, 32'd0, 32'd0, 5'd20);
        send(32'h1800_0803, 32'd8, 32'd0, 32'd0, 5'd21);
        send(32'h1800_0803, 32'd9, 32'd0, 32'd0, 5'd22);
        tick();
        tick();
        chk("mid_buffered", 64'(rsp_valid_o), 64'd1);
        rst_ni = 1'b0;
        tick();
        chk("mid_rst_valid", 64'(rsp_valid_o), 64'd0);
        chk("mid_rst_ready", 64'(req_ready_o), 64'd1);
        chk("mid_rst_data",  64'(rsp_data_o),  64'd0);
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        seen        = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rsp_valid_o) seen = 1'b1;
        end
        chk("mid_no_stale", 64'(seen), 64'd0);
        rsp_ready_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
